// File: rtl/carbonio_pio_pkg.sv
// Shared constants for the CarbonIO timestamped parallel I/O block.
package carbonio_pio_pkg;

    // Bit positions inside irq_en
    localparam int IRQ_EDGE  = 0;
    localparam int IRQ_MATCH = 1;
    localparam int IRQ_OVF   = 2;

    // Bit positions inside status_clr
    localparam int CLR_OVF   = 0;
    localparam int CLR_MATCH = 1;

    // Default free-running timestamp width
    localparam int TS_WIDTH_DEFAULT = 16;

    // Width of the glitch-filter length field and per-bit counters
    localparam int FILTER_LEN_W = 8;

endpackage

// File: rtl/carbonio_fifo.sv
// Edge-event FIFO. Storage is cleared by reset so a drained or freshly reset
// queue never exposes stale entries; the head is presented combinationally
// and reads as zero while the queue is empty.
module carbonio_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A push into a full queue is only accepted when a pop frees the slot in
    // the same cycle; a pop on an empty queue is ignored.
    always_comb begin
        do_push = push & (~full | pop);
        do_pop  = pop & ~empty;
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap explicitly so DEPTH need not be a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry, zero while empty
    always_comb begin
        head = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: rtl/carbonio_pio_ts.sv
// CarbonIO second-generation parallel I/O: synchronizer, per-bit glitch
// filter, edge qualification into a timestamped event FIFO, pattern match
// and interrupt generation, plus the output/direction registers.
module carbonio_pio_ts
    import carbonio_pio_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int EDGE_FIFO_DEPTH = 16,
    parameter int TS_WIDTH        = TS_WIDTH_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic [WIDTH-1:0]                     pio_in,
    output logic [WIDTH-1:0]                     pio_out,
    output logic [WIDTH-1:0]                     pio_dir,
    input  logic                                 out_we,
    input  logic                                 out_set_we,
    input  logic                                 out_clr_we,
    input  logic [WIDTH-1:0]                     out_wdata,
    input  logic                                 dir_we,
    input  logic [WIDTH-1:0]                     dir_wdata,
    input  logic                                 cfg_we,
    input  logic [FILTER_LEN_W-1:0]              filter_len_wdata,
    input  logic [WIDTH-1:0]                     rise_en_wdata,
    input  logic [WIDTH-1:0]                     fall_en_wdata,
    input  logic [2:0]                           irq_en_wdata,
    input  logic                                 match_we,
    input  logic [WIDTH-1:0]                     match_value_wdata,
    input  logic [WIDTH-1:0]                     match_mask_wdata,
    input  logic                                 edge_pop,
    output logic [WIDTH-1:0]                     edge_value,
    output logic [WIDTH-1:0]                     edge_mask,
    output logic [TS_WIDTH-1:0]                  edge_ts,
    output logic [$clog2(EDGE_FIFO_DEPTH+1)-1:0] edge_count,
    input  logic [1:0]                           status_clr,
    output logic                                 edge_overflow,
    output logic                                 match_sticky,
    output logic                                 edge_pulse,
    output logic                                 match_pulse,
    output logic                                 irq
);
    localparam int FW = TS_WIDTH + 2*WIDTH;

    logic [FILTER_LEN_W-1:0] filter_len;
    logic [WIDTH-1:0]        rise_en;
    logic [WIDTH-1:0]        fall_en;
    logic [2:0]              irq_en;
    logic [WIDTH-1:0]        match_value;
    logic [WIDTH-1:0]        match_mask;

    logic [WIDTH-1:0]        sync_meta;
    logic [WIDTH-1:0]        sync;
    logic [WIDTH-1:0]        stable;
    logic [WIDTH-1:0]        chg;
    logic [WIDTH-1:0]        stable_new;
    logic [WIDTH-1:0]        mask_next;
    logic [TS_WIDTH-1:0]     ts_q;

    logic                    push_valid;
    logic [FW-1:0]           push_data;
    logic [FW-1:0]           head;
    logic                    fifo_full;
    logic                    ovf_set;

    logic                    m;
    logic                    m_prev;

    // Software-visible configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filter_len  <= '0;
            rise_en     <= '0;
            fall_en     <= '0;
            irq_en      <= '0;
            match_value <= '0;
            match_mask  <= '0;
        end else begin
            if (cfg_we) begin
                filter_len <= filter_len_wdata;
                rise_en    <= rise_en_wdata;
                fall_en    <= fall_en_wdata;
                irq_en     <= irq_en_wdata;
            end
            if (match_we) begin
                match_value <= match_value_wdata;
                match_mask  <= match_mask_wdata;
            end
        end
    end

    // Output and direction registers; a full write beats set/clear, clear beats set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pio_out <= '0;
            pio_dir <= '0;
        end else begin
            if (out_we) begin
                pio_out <= out_wdata;
            end else begin
                pio_out <= (pio_out | (out_set_we ? out_wdata : '0))
                         & ~(out_clr_we ? out_wdata : '0);
            end
            if (dir_we) begin
                pio_dir <= dir_wdata;
            end
        end
    end

    // Two-flop synchronizer and free-running timestamp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
            ts_q      <= '0;
        end else begin
            sync_meta <= pio_in;
            sync      <= sync_meta;
            if (enable) begin
                ts_q <= ts_q + TS_WIDTH'(1);
            end
        end
    end

    // Per-bit glitch filter: a bit must disagree with its stable value for
    // filter_len+1 consecutive cycles before the stable value follows it.
    // While disabled the stable value tracks the pin so re-enabling is quiet.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_filter
        logic [FILTER_LEN_W-1:0] cnt;
        logic                    bit_stable;

        assign stable[gi] = bit_stable;
        assign chg[gi]    = enable & (sync[gi] ^ bit_stable) & (cnt == filter_len);

        // Counter and stable value for this pin
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt        <= '0;
                bit_stable <= 1'b0;
            end else if (!enable) begin
                cnt        <= '0;
                bit_stable <= sync[gi];
            end else if (sync[gi] == bit_stable) begin
                cnt        <= '0;
            end else if (cnt == filter_len) begin
                cnt        <= '0;
                bit_stable <= sync[gi];
            end else begin
                cnt        <= cnt + FILTER_LEN_W'(1);
            end
        end
    end

    // Edge qualification against the rise/fall enables
    always_comb begin
        stable_new = (stable & ~chg) | (sync & chg);
        mask_next  = chg & ((sync & rise_en) | (~sync & fall_en));
    end

    // Registered push request; it doubles as the edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_valid <= 1'b0;
            push_data  <= '0;
        end else begin
            push_valid <= |mask_next;
            push_data  <= {ts_q, mask_next, stable_new};
        end
    end

    assign edge_pulse = push_valid;
    assign ovf_set    = push_valid & fifo_full & ~edge_pop;

    carbonio_fifo #(
        .WIDTH (FW),
        .DEPTH (EDGE_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_valid),
        .push_data (push_data),
        .pop       (edge_pop),
        .head      (head),
        .count     (edge_count),
        .full      (fifo_full)
    );

    assign {edge_ts, edge_mask, edge_value} = head;

    // Pattern match on the filtered inputs; an all-zero mask always matches
    assign m = (((stable ^ match_value) & match_mask) == '0);

    // Rising edge of the match condition, suppressed while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev      <= 1'b0;
            match_pulse <= 1'b0;
        end else if (!enable) begin
            m_prev      <= 1'b0;
            match_pulse <= 1'b0;
        end else begin
            m_prev      <= m;
            match_pulse <= m & ~m_prev;
        end
    end

    // Sticky status bits (a new event beats a simultaneous clear) and interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_overflow <= 1'b0;
            match_sticky  <= 1'b0;
            irq           <= 1'b0;
        end else begin
            edge_overflow <= ovf_set | (edge_overflow & ~status_clr[CLR_OVF]);
            match_sticky  <= match_pulse | (match_sticky & ~status_clr[CLR_MATCH]);
            irq           <= (irq_en[IRQ_EDGE]  & (edge_count != '0))
                           | (irq_en[IRQ_MATCH] & match_sticky)
                           | (irq_en[IRQ_OVF]   & edge_overflow);
        end
    end

endmodule

// File: tb/tb_carbonio_pio_ts.sv
// Directed bench for carbonio_pio_ts: latency, glitch filter, edge masks,
// FIFO overflow, match/IRQ, output registers and asynchronous reset.
module tb_carbonio_pio_ts;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int TW = 16;
    localparam int CW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [W-1:0]  pio_in;
    logic [W-1:0]  pio_out;
    logic [W-1:0]  pio_dir;
    logic          out_we, out_set_we, out_clr_we;
    logic [W-1:0]  out_wdata;
    logic          dir_we;
    logic [W-1:0]  dir_wdata;
    logic          cfg_we;
    logic [7:0]    filter_len_wdata;
    logic [W-1:0]  rise_en_wdata, fall_en_wdata;
    logic [2:0]    irq_en_wdata;
    logic          match_we;
    logic [W-1:0]  match_value_wdata, match_mask_wdata;
    logic          edge_pop;
    logic [W-1:0]  edge_value, edge_mask;
    logic [TW-1:0] edge_ts;
    logic [CW-1:0] edge_count;
    logic [1:0]    status_clr;
    logic          edge_overflow, match_sticky, edge_pulse, match_pulse, irq;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            match_pulses = 0;
    int            edge_pulses = 0;
    logic [TW-1:0] ts_model;

    always #5 clk = ~clk;

    carbonio_pio_ts #(
        .WIDTH           (W),
        .EDGE_FIFO_DEPTH (D),
        .TS_WIDTH        (TW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .pio_in            (pio_in),
        .pio_out           (pio_out),
        .pio_dir           (pio_dir),
        .out_we            (out_we),
        .out_set_we        (out_set_we),
        .out_clr_we        (out_clr_we),
        .out_wdata         (out_wdata),
        .dir_we            (dir_we),
        .dir_wdata         (dir_wdata),
        .cfg_we            (cfg_we),
        .filter_len_wdata  (filter_len_wdata),
        .rise_en_wdata     (rise_en_wdata),
        .fall_en_wdata     (fall_en_wdata),
        .irq_en_wdata      (irq_en_wdata),
        .match_we          (match_we),
        .match_value_wdata (match_value_wdata),
        .match_mask_wdata  (match_mask_wdata),
        .edge_pop          (edge_pop),
        .edge_value        (edge_value),
        .edge_mask         (edge_mask),
        .edge_ts           (edge_ts),
        .edge_count        (edge_count),
        .status_clr        (status_clr),
        .edge_overflow     (edge_overflow),
        .match_sticky      (match_sticky),
        .edge_pulse        (edge_pulse),
        .match_pulse       (match_pulse),
        .irq               (irq)
    );

    // Reference timestamp: counts enabled clock edges since reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_model <= '0;
        else if (enable) ts_model <= ts_model + 16'd1;
    end

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (match_pulse) match_pulses <= match_pulses + 1;
        if (edge_pulse)  edge_pulses  <= edge_pulses + 1;
    end

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance n active edges, ending at the following falling edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic cfg(input logic [7:0] l, input logic [W-1:0] r, input logic [W-1:0] f,
                       input logic [2:0] ie);
        filter_len_wdata = l;
        rise_en_wdata    = r;
        fall_en_wdata    = f;
        irq_en_wdata     = ie;
        cfg_we           = 1'b1;
        step(1);
        cfg_we           = 1'b0;
    endtask

    task automatic pop_one();
        edge_pop = 1'b1;
        step(1);
        edge_pop = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] exp_ts;
        logic [TW-1:0] t1;
        logic [TW-1:0] t2;
        int            snap_m;
        int            snap_e;

        rst_n = 1'b0; enable = 1'b0; pio_in = '0;
        out_we = 0; out_set_we = 0; out_clr_we = 0; out_wdata = '0;
        dir_we = 0; dir_wdata = '0; cfg_we = 0; filter_len_wdata = '0;
        rise_en_wdata = '0; fall_en_wdata = '0; irq_en_wdata = '0;
        match_we = 0; match_value_wdata = '0; match_mask_wdata = '0;
        edge_pop = 0; status_clr = '0;

        @(negedge clk); @(negedge clk);
        expect_eq("reset_count", edge_count, 0);
        expect_eq("reset_head",  {edge_ts, edge_mask, edge_value}, 0);
        expect_eq("reset_flags", {edge_overflow, match_sticky, edge_pulse, match_pulse, irq}, 0);
        rst_n = 1'b1;
        step(1);

        // Latency with L=0, rising edges on all bits
        cfg(8'd0, '1, '0, 3'b000);
        enable = 1'b1;
        step(3);
        pio_in = 32'h1;
        step(1);
        step(1);
        exp_ts = ts_model;
        expect_eq("lat_pulse_early", edge_pulse, 0);
        step(1);
        expect_eq("lat_pulse", edge_pulse, 1);
        expect_eq("lat_count_early", edge_count, 0);
        step(1);
        expect_eq("lat_count", edge_count, 1);
        expect_eq("lat_entry", {edge_ts, edge_mask, edge_value}, {exp_ts, 32'h1, 32'h1});
        pop_one();
        expect_eq("lat_popped", edge_count, 0);

        // Falling edge with fall_en=0 updates silently
        pio_in = 32'h0;
        step(6);
        expect_eq("silent_fall", edge_count, 0);

        // L=3: a 2-cycle glitch is rejected, a 5-cycle pulse gives rise and fall
        cfg(8'd3, '1, '1, 3'b000);
        pio_in = 32'h10;
        step(2);
        pio_in = 32'h0;
        step(10);
        expect_eq("glitch_count", edge_count, 0);
        pio_in = 32'h10;
        step(5);
        pio_in = 32'h0;
        step(15);
        expect_eq("pulse_count", edge_count, 2);
        expect_eq("pulse_rise", {edge_mask, edge_value}, {32'h10, 32'h10});
        t1 = edge_ts;
        pop_one();
        expect_eq("pulse_fall", {edge_mask, edge_value}, {32'h10, 32'h0});
        t2 = edge_ts;
        expect_eq("pulse_ts_diff", t2 - t1, 5);
        pop_one();

        // Per-bit rise/fall qualification
        cfg(8'd0, 32'h1, 32'h2, 3'b000);
        pio_in = 32'h3;
        step(6);
        pio_in = 32'h0;
        step(6);
        expect_eq("qual_count", edge_count, 2);
        expect_eq("qual_first", {edge_mask, edge_value}, {32'h1, 32'h3});
        pop_one();
        expect_eq("qual_second", {edge_mask, edge_value}, {32'h2, 32'h0});
        pop_one();

        // Overflow: 17 edges into a 16-entry queue
        cfg(8'd0, '1, '1, 3'b100);
        for (int i = 0; i < 17; i++) begin
            pio_in = pio_in ^ 32'h1;
            step(4);
        end
        step(2);
        expect_eq("ovf_count", edge_count, 16);
        expect_eq("ovf_flag", edge_overflow, 1);
        expect_eq("ovf_irq", irq, 1);
        status_clr = 2'b01;
        step(1);
        status_clr = 2'b00;
        step(1);
        expect_eq("ovf_cleared", {edge_overflow, irq}, 0);
        // Push and pop in the same cycle while full
        pio_in = pio_in ^ 32'h1;
        step(3);
        expect_eq("pp_pulse", edge_pulse, 1);
        edge_pop = 1'b1;
        step(1);
        edge_pop = 1'b0;
        step(1);
        expect_eq("pp_count", edge_count, 16);
        expect_eq("pp_no_ovf", edge_overflow, 0);
        expect_eq("pp_head", {edge_mask, edge_value}, {32'h1, 32'h0});
        edge_pop = 1'b1;
        step(11);
        edge_pop = 1'b0;
        expect_eq("drain_count", edge_count, 5);

        // Output and direction registers
        out_we = 1; out_wdata = 32'hF0; step(1); out_we = 0;
        expect_eq("out_write", pio_out, 32'hF0);
        out_set_we = 1; out_wdata = 32'h0F; step(1); out_set_we = 0;
        expect_eq("out_set", pio_out, 32'hFF);
        out_set_we = 1; out_clr_we = 1; out_wdata = 32'h81; step(1);
        out_set_we = 0; out_clr_we = 0;
        expect_eq("out_set_clr", pio_out, 32'h7E);
        out_we = 1; out_clr_we = 1; out_wdata = 32'h12; step(1);
        out_we = 0; out_clr_we = 0;
        expect_eq("out_we_wins", pio_out, 32'h12);
        dir_we = 1; dir_wdata = 32'hAA; step(1); dir_we = 0;
        expect_eq("dir_write", pio_dir, 32'hAA);

        // Asynchronous reset mid-filter with 5 queued entries
        cfg(8'd10, '1, '1, 3'b000);
        pio_in = 32'h4;
        step(5);
        #2 rst_n = 1'b0;
        #1;
        expect_eq("arst_count", edge_count, 0);
        expect_eq("arst_regs", {pio_out, pio_dir}, 0);
        expect_eq("arst_head", {edge_ts, edge_mask, edge_value}, 0);
        expect_eq("arst_flags", {edge_overflow, match_sticky, edge_pulse, irq}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        snap_e = edge_pulses;
        step(10);
        expect_eq("arst_no_event", edge_count, 0);
        expect_eq("arst_no_pulse", edge_pulses - snap_e, 0);
        expect_eq("mask0_match", match_sticky, 1);

        // Pattern match with mask 0xF0 / value 0x50
        cfg(8'd0, '0, '0, 3'b010);
        match_value_wdata = 32'h50; match_mask_wdata = 32'hF0; match_we = 1;
        step(1);
        match_we = 0;
        status_clr = 2'b10;
        step(1);
        status_clr = 2'b00;
        step(1);
        expect_eq("match_clr0", match_sticky, 0);
        snap_m = match_pulses;
        pio_in = 32'h5A;
        step(8);
        expect_eq("match_pulses", match_pulses - snap_m, 1);
        expect_eq("match_sticky", match_sticky, 1);
        expect_eq("match_irq", irq, 1);
        status_clr = 2'b10;
        step(1);
        status_clr = 2'b00;
        step(1);
        expect_eq("match_cleared", {match_sticky, irq}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
